fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
Shares one single-port framebuffer BRAM (160x240 pixels, 7-bit colour) between the TIA pixel writer and the display scanout reader. TIA writes go through a small write FIFO; scanout reads have priority, with a starvation guard and a frame-clear engine. Sits between the TIA video outputs (vid_addr/vid_out/vid_wr) and the HDMI scanout/BRAM.

Parameters:
ADDR_WIDTH, 16, framebuffer address width
DATA_WIDTH, 7, pixel colour width
FB_SIZE, 38400, number of valid pixel locations (160*240)
FIFO_DEPTH, 4, write FIFO entries, power of two, >=2
MAX_RD_RUN, 8, consecutive read grants allowed while FIFO non-empty before one forced write

Ports:
clk_i  in  1  single clock for all logic
rst_i  in  1  synchronous active-high reset
wr_i  in  1  TIA pixel write strobe (vid_wr)
wr_adr_i  in  ADDR_WIDTH  TIA pixel address (vid_addr)
wr_dat_i  in  DATA_WIDTH  TIA pixel colour (vid_out)
rd_req_i  in  1  scanout read request
rd_adr_i  in  ADDR_WIDTH  scanout read address
rd_ack_o  out  1  read granted this cycle (combinational)
rd_valid_o  out  1  rd_dat_o valid (one cycle after ack)
rd_dat_o  out  DATA_WIDTH  read data
clr_i  in  1  pulse: start clearing framebuffer
clr_color_i  in  DATA_WIDTH  clear colour, sampled when clr_i accepted
busy_o  out  1  clear in progress
fifo_full_o  out  1  write FIFO full
ovf_o  out  1  sticky: a write was dropped (FIFO full)
mem_adr_o  out  ADDR_WIDTH  BRAM address (combinational from grant)
mem_we_o  out  1  BRAM write enable
mem_dat_o  out  DATA_WIDTH  BRAM write data
mem_dat_i  in  DATA_WIDTH  BRAM read data, registered, 1-cycle latency

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: FIFO empty, count 0; rd_valid_o=0, rd_dat_o=0, busy_o=0, fifo_full_o=0, ovf_o=0, read-run counter 0, clear counter 0; mem_we_o=0.
- Write push: wr_i=1 and wr_adr_i<FB_SIZE and FIFO not full -> entry pushed. wr_adr_i>=FB_SIZE -> silently discarded. FIFO full (including full at cycle start, even if popping same cycle) -> discarded, ovf_o<=1, stays 1 until rst_i.
- fifo_full_o = (count==FIFO_DEPTH), registered state, no comb path from wr_i.
- Grant per cycle, one of: RD, CLR, WR, NONE. Priority:
  1. FORCE_WR: run counter==MAX_RD_RUN and FIFO non-empty -> WR; rd_ack_o=0 (scanout retries).
  2. rd_req_i -> RD, rd_ack_o=1.
  3. busy_o -> CLR.
  4. FIFO non-empty -> WR (pop).
  5. NONE.
- Run counter: +1 on RD grant while FIFO non-empty, saturates at MAX_RD_RUN; cleared on any WR grant or when FIFO empty.
- RD: mem_adr_o=rd_adr_i, mem_we_o=0; next cycle rd_valid_o=1, rd_dat_o=mem_dat_i. Read latency 1 cycle from ack. rd_adr_i>=FB_SIZE still granted, data undefined.
- WR: mem_adr_o/mem_dat_o = FIFO head, mem_we_o=1, head popped. Push and pop same cycle: count unchanged.
- CLR: clr_i while !busy_o -> busy_o<=1, clear counter<=0, colour latched. Each CLR grant writes colour to counter address, counter+1; after writing FB_SIZE-1, busy_o<=0. clr_i while busy_o ignored. FIFO still accepts pushes during clear but does not drain (except forced writes); entries drain after clear, overwriting cleared pixels (TIA pixels win).
- NONE/CLR/RD: FIFO head unchanged; mem_adr_o=0 and mem_we_o=0 on NONE.
- Wrap: FIFO pointers wrap modulo FIFO_DEPTH; clear counter never exceeds FB_SIZE-1.
- Reset mid-clear or with FIFO occupied: clear aborted, FIFO contents discarded, no BRAM write in the reset cycle.

Test Plan:
- Writes only: wr_i at adr 0,1,2 data 5,6,7 back-to-back, no reads -> mem_we_o for adr 0,1,2 on cycles 1,2,3 in order, FIFO empty after.
- Read priority/latency: rd_req_i at adr 100 with FIFO holding 2 entries, MAX_RD_RUN=8 -> rd_ack_o=1 same cycle, rd_valid_o next cycle with BRAM contents; writes drain once rd_req_i drops.
- Starvation: rd_req_i held high 20 cycles, FIFO non-empty -> rd_ack_o low in cycles 9 and 18, one write each, rd_req_i continuous.
- Overflow: FIFO_DEPTH=4, 6 writes while rd_req_i held high with MAX_RD_RUN large -> fifo_full_o=1 after 4, writes 5-6 dropped, ovf_o=1 until reset.
- Clear: clr_i with colour 0x2A, no reads -> busy_o high exactly 38400 cycles, every address 0..38399 written with 0x2A; a TIA write issued mid-clear lands in BRAM after busy_o falls.
- Reset mid-clear at counter 1000 -> busy_o=0, no further writes, FIFO empty, ovf_o=0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer BRAM arbiter: scanout reads win, TIA writes are buffered
// in a small FIFO with a starvation guard, and a clear engine fills the frame.
module fb_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 7,
  parameter int unsigned FB_SIZE    = 38400,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_RD_RUN = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] wr_adr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_adr_i,
  output logic                  rd_ack_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_dat_o,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] clr_color_i,
  output logic                  busy_o,
  output logic                  fifo_full_o,
  output logic                  ovf_o,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_dat_o,
  input  logic [DATA_WIDTH-1:0] mem_dat_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RUN_W = $clog2(MAX_RD_RUN + 1);

  localparam logic [ADDR_WIDTH-1:0] FB_LAST  = ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [RUN_W-1:0]      RUN_MAX  = RUN_W'(MAX_RD_RUN);

  typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_CLR, GNT_WR} grant_e;

  logic [ADDR_WIDTH-1:0] fifo_adr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_dat_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] clr_col_q, clr_col_d;
  logic                  rd_valid_q, rd_valid_d;

  grant_e grant;
  logic   fifo_empty;
  logic   force_wr;
  logic   wr_in_range;
  logic   push_ok;
  logic   pop;

  assign fifo_empty  = (count_q == '0);
  assign force_wr    = (run_q == RUN_MAX) && !fifo_empty;
  assign wr_in_range = (wr_adr_i <= FB_LAST);
  assign push_ok     = !rst_i && wr_i && wr_in_range && !full_q;
  assign pop         = (grant == GNT_WR);

  // Port grant; nothing is granted in a reset cycle so the BRAM is never written then.
  always_comb begin
    grant = GNT_NONE;
    if (!rst_i) begin
      if (force_wr)        grant = GNT_WR;
      else if (rd_req_i)   grant = GNT_RD;
      else if (busy_q)     grant = GNT_CLR;
      else if (!fifo_empty) grant = GNT_WR;
    end
  end

  always_comb begin
    mem_adr_o = '0;
    mem_we_o  = 1'b0;
    mem_dat_o = '0;
    case (grant)
      GNT_RD:  mem_adr_o = rd_adr_i;
      GNT_CLR: begin
        mem_adr_o = clr_cnt_q;
        mem_we_o  = 1'b1;
        mem_dat_o = clr_col_q;
      end
      GNT_WR: begin
        mem_adr_o = fifo_adr_q[rd_ptr_q];
        mem_we_o  = 1'b1;
        mem_dat_o = fifo_dat_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  assign rd_ack_o    = (grant == GNT_RD);
  assign rd_valid_o  = rd_valid_q;
  assign rd_dat_o    = rd_valid_q ? mem_dat_i : '0;
  assign busy_o      = busy_q;
  assign fifo_full_o = full_q;
  assign ovf_o       = ovf_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    run_d      = run_q;
    busy_d     = busy_q;
    clr_cnt_d  = clr_cnt_q;
    clr_col_d  = clr_col_q;
    rd_valid_d = (grant == GNT_RD);

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
    full_d = (count_d == CNT_FULL);

    // Fullness is judged at cycle start, so a same-cycle pop does not rescue the write.
    if (wr_i && wr_in_range && full_q) ovf_d = 1'b1;

    if (pop || fifo_empty)                     run_d = '0;
    else if (grant == GNT_RD && run_q != RUN_MAX) run_d = run_q + RUN_W'(1);

    if (grant == GNT_CLR) begin
      if (clr_cnt_q == FB_LAST) busy_d    = 1'b0;
      else                      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
    end
    if (clr_i && !busy_q) begin
      busy_d    = 1'b1;
      clr_cnt_d = '0;
      clr_col_d = clr_color_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      run_q      <= '0;
      busy_q     <= 1'b0;
      clr_cnt_q  <= '0;
      clr_col_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_col_q  <= clr_col_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // FIFO payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_adr_q[wr_ptr_q] <= wr_adr_i;
      fifo_dat_q[wr_ptr_q] <= wr_dat_i;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed vector table, corner sequences and random
// traffic, all checked against a queue-based reference model with a BRAM model.
module tb_fb_port_arbiter;

  localparam int FB    = 38400;
  localparam int DEPTH = 4;
  localparam int MAXR  = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, wr_i = 1'b0, rd_req_i = 1'b0, clr_i = 1'b0;
  logic [15:0] wr_adr_i = '0, rd_adr_i = '0;
  logic [6:0]  wr_dat_i = '0, clr_color_i = '0;
  logic        rd_ack_o, rd_valid_o, busy_o, fifo_full_o, ovf_o, mem_we_o;
  logic [6:0]  rd_dat_o, mem_dat_o, mem_dat_i;
  logic [15:0] mem_adr_o;

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
    .rd_req_i(rd_req_i), .rd_adr_i(rd_adr_i), .rd_ack_o(rd_ack_o), .rd_valid_o(rd_valid_o),
    .rd_dat_o(rd_dat_o), .clr_i(clr_i), .clr_color_i(clr_color_i), .busy_o(busy_o),
    .fifo_full_o(fifo_full_o), .ovf_o(ovf_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i)
  );

  // Registered single-port BRAM model.
  logic [6:0] bram [0:65535];
  always @(posedge clk) begin
    if (mem_we_o) bram[mem_adr_o] <= mem_dat_o;
    mem_dat_i <= bram[mem_adr_o];
  end

  // Reference model state.
  typedef struct { logic [15:0] a; logic [6:0] d; } ent_t;
  ent_t       q[$];
  int         run, ccnt, g;
  bit         busy, ovf, rdv, rdd_known, known;
  logic [6:0] ccol, rdd;
  logic [6:0] ref_mem [0:65535];

  int ntests = 0, nfail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Apply inputs (at negedge) and compare every output with the model's prediction.
  task automatic drive_and_check(input bit r, input bit w, input logic [15:0] wa,
                                 input logic [6:0] wd, input bit rq, input logic [15:0] ra,
                                 input bit c, input logic [6:0] cc);
    logic [15:0] ea;
    logic [6:0]  ed;
    rst_i = r; wr_i = w; wr_adr_i = wa; wr_dat_i = wd;
    rd_req_i = rq; rd_adr_i = ra; clr_i = c; clr_color_i = cc;
    #1;
    if (r)                         g = 0;
    else if (run == MAXR && q.size() > 0) g = 3;
    else if (rq)                   g = 1;
    else if (busy)                 g = 2;
    else if (q.size() > 0)         g = 3;
    else                           g = 0;
    ea = 16'd0; ed = 7'd0;
    if (g == 1) ea = ra;
    if (g == 2) begin ea = 16'(ccnt); ed = ccol; end
    if (g == 3) begin ea = q[0].a; ed = q[0].d; end
    chk("rd_ack", 32'(rd_ack_o), 32'(g == 1));
    chk("mem_we", 32'(mem_we_o), 32'(g >= 2));
    chk("mem_adr", 32'(mem_adr_o), 32'(ea));
    if (g >= 2) chk("mem_dat", 32'(mem_dat_o), 32'(ed));
    if (known) begin
      chk("busy", 32'(busy_o), 32'(busy));
      chk("fifo_full", 32'(fifo_full_o), 32'(q.size() == DEPTH));
      chk("ovf", 32'(ovf_o), 32'(ovf));
      chk("rd_valid", 32'(rd_valid_o), 32'(rdv));
      if (rdv && rdd_known) chk("rd_dat", 32'(rd_dat_o), 32'(rdd));
    end
  endtask

  // Clock edge: advance the model by the rules, then return to the next negedge.
  task automatic advance();
    bit ne, fs, started;
    @(posedge clk);
    if (rst_i) begin
      q.delete(); run = 0; busy = 0; ccnt = 0; ovf = 0; rdv = 0; known = 1;
    end else begin
      if (g == 3) ref_mem[q[0].a] = q[0].d;
      if (g == 2) ref_mem[ccnt] = ccol;
      rdv = (g == 1);
      if (g == 1) begin rdd = ref_mem[rd_adr_i]; rdd_known = (int'(rd_adr_i) < FB); end
      ne = (q.size() > 0);
      fs = (q.size() == DEPTH);
      if (g == 3 || !ne)              run = 0;
      else if (g == 1 && run < MAXR)  run++;
      if (g == 3) void'(q.pop_front());
      if (wr_i && int'(wr_adr_i) < FB) begin
        if (fs) ovf = 1;
        else    q.push_back('{a: wr_adr_i, d: wr_dat_i});
      end
      started = clr_i && !busy;
      if (g == 2) begin
        if (ccnt == FB - 1) busy = 0;
        else                ccnt++;
      end
      if (started) begin busy = 1; ccnt = 0; ccol = clr_color_i; end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit r, input bit w, input logic [15:0] wa, input logic [6:0] wd,
                     input bit rq, input logic [15:0] ra);
    drive_and_check(r, w, wa, wd, rq, ra, 1'b0, 7'd0);
    advance();
  endtask

  typedef struct {
    bit wr; logic [15:0] wadr; logic [6:0] wdat; bit rd; logic [15:0] radr;
    bit e_ack; bit e_we; logic [15:0] e_adr; logic [6:0] e_dat; bit e_rdv; logic [6:0] e_rdd; bit e_full;
  } vec_t;
  vec_t tbl [11];

  int lows, low_pos[$], bcnt, mism, n2a;

  initial begin
    for (int i = 0; i < 65536; i++) begin bram[i] = 7'd0; ref_mem[i] = 7'd0; end
    run = 0; busy = 0; ccnt = 0; ovf = 0; rdv = 0; known = 0; g = 0; rdd_known = 0;
    ccol = 7'd0; rdd = 7'd0;

    // Writes-only then read priority/latency with two queued writes.
    tbl[0]  = '{1'b1, 16'd0,  7'd5, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0,  7'd0, 1'b0, 7'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'd1,  7'd6, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0,  7'd5, 1'b0, 7'd0, 1'b0};
    tbl[2]  = '{1'b1, 16'd2,  7'd7, 1'b0, 16'd0, 1'b0, 1'b1, 16'd1,  7'd6, 1'b0, 7'd0, 1'b0};
    tbl[3]  = '{1'b0, 16'd0,  7'd0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd2,  7'd7, 1'b0, 7'd0, 1'b0};
    tbl[4]  = '{1'b0, 16'd0,  7'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0,  7'd0, 1'b0, 7'd0, 1'b0};
    tbl[5]  = '{1'b1, 16'd10, 7'd1, 1'b1, 16'd1, 1'b1, 1'b0, 16'd1,  7'd0, 1'b0, 7'd0, 1'b0};
    tbl[6]  = '{1'b1, 16'd11, 7'd2, 1'b1, 16'd2, 1'b1, 1'b0, 16'd2,  7'd0, 1'b1, 7'd6, 1'b0};
    tbl[7]  = '{1'b0, 16'd0,  7'd0, 1'b1, 16'd0, 1'b1, 1'b0, 16'd0,  7'd0, 1'b1, 7'd7, 1'b0};
    tbl[8]  = '{1'b0, 16'd0,  7'd0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd10, 7'd1, 1'b1, 7'd5, 1'b0};
    tbl[9]  = '{1'b0, 16'd0,  7'd0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd11, 7'd2, 1'b0, 7'd0, 1'b0};
    tbl[10] = '{1'b0, 16'd0,  7'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0,  7'd0, 1'b0, 7'd0, 1'b0};

    @(negedge clk);
    cyc(1'b1, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_full", 32'(fifo_full_o), 32'd0);
    chk("reset_ovf", 32'(ovf_o), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid_o), 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive_and_check(1'b0, tbl[i].wr, tbl[i].wadr, tbl[i].wdat, tbl[i].rd, tbl[i].radr, 1'b0, 7'd0);
      chk("tbl_ack", 32'(rd_ack_o), 32'(tbl[i].e_ack));
      chk("tbl_we", 32'(mem_we_o), 32'(tbl[i].e_we));
      chk("tbl_adr", 32'(mem_adr_o), 32'(tbl[i].e_adr));
      if (tbl[i].e_we) chk("tbl_dat", 32'(mem_dat_o), 32'(tbl[i].e_dat));
      chk("tbl_rdv", 32'(rd_valid_o), 32'(tbl[i].e_rdv));
      if (tbl[i].e_rdv) chk("tbl_rdd", 32'(rd_dat_o), 32'(tbl[i].e_rdd));
      chk("tbl_full", 32'(fifo_full_o), 32'(tbl[i].e_full));
      advance();
    end

    // Starvation guard: continuous reads with three queued writes.
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      drive_and_check(1'b0, i < 3, 16'(300 + i), 7'(i + 1), 1'b1, 16'(i), 1'b0, 7'd0);
      if (rd_ack_o !== 1'b1) begin lows++; low_pos.push_back(i); end
      advance();
    end
    chk("starve_lows", 32'(lows), 32'd2);
    if (low_pos.size() == 2) begin
      chk("starve_pos0", 32'(low_pos[0]), 32'd9);
      chk("starve_pos1", 32'(low_pos[1]), 32'd18);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0);

    // Overflow: six writes while reads hold the port.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 16'(400 + i), 7'(i + 9), 1'b1, 16'd0);
    chk("ovf_full", 32'(fifo_full_o), 32'd1);
    chk("ovf_set", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0);
    chk("ovf_sticky", 32'(ovf_o), 32'd1);
    chk("ovf_drained", 32'(fifo_full_o), 32'd0);

    // Frame clear with a TIA write issued mid-clear.
    drive_and_check(1'b0, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0, 1'b1, 7'h2A);
    advance();
    bcnt = 0;
    for (int i = 0; i < 40000 && busy_o === 1'b1; i++) begin
      bcnt++;
      drive_and_check(1'b0, bcnt == 20000, 16'd500, 7'h11, 1'b0, 16'd0, bcnt == 300, 7'h05);
      advance();
    end
    chk("clr_busy_cycles", 32'(bcnt), 32'd38400);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0);
    chk("clr_tia_wins", 32'(bram[500]), 32'h11);
    mism = 0; n2a = 0;
    for (int i = 0; i < FB; i++) begin
      if (bram[i] !== ref_mem[i]) mism++;
      if (bram[i] === 7'h2A) n2a++;
    end
    chk("clr_mem_match", 32'(mism), 32'd0);
    chk("clr_color_count", 32'(n2a), 32'(FB - 1));

    // Reset mid-clear with queued writes.
    drive_and_check(1'b0, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0, 1'b1, 7'h33);
    advance();
    for (int i = 0; i < 2000 && ccnt < 1000; i++)
      cyc(1'b0, ccnt >= 995, 16'(600 + i), 7'h44, 1'b0, 16'd0);
    chk("rstclr_at", 32'(ccnt), 32'd1000);
    chk("rstclr_fifo_used", 32'(q.size() > 0), 32'd1);
    cyc(1'b1, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0);
    chk("rstclr_busy", 32'(busy_o), 32'd0);
    chk("rstclr_full", 32'(fifo_full_o), 32'd0);
    chk("rstclr_ovf", 32'(ovf_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive_and_check(1'b0, 1'b0, 16'd0, 7'd0, 1'b0, 16'd0, 1'b0, 7'd0);
      chk("rstclr_idle_we", 32'(mem_we_o), 32'd0);
      advance();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] wa, ra;
      wa = ($urandom_range(0, 7) == 0) ? 16'(FB + $urandom_range(0, 99)) : 16'($urandom_range(0, FB - 1));
      ra = ($urandom_range(0, 15) == 0) ? 16'(FB + $urandom_range(0, 99)) : 16'($urandom_range(0, FB - 1));
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, wa, 7'($urandom),
          $urandom_range(0, 3) != 0, ra);
    end
    mism = 0;
    for (int i = 0; i < FB; i++) if (bram[i] !== ref_mem[i]) mism++;
    chk("rand_mem_match", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
